// File: rtl/bip_alu_acc.sv
// Accumulator ALU with signed flags and an optional multi-cycle shift-add multiplier.
// The multiplier exists only when BIP_ALU_MUL_EN is defined; otherwise op 111 acts as NOP.
module bip_alu_acc #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic [3:0]       flags,
  output logic             out_valid
);

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic             upd_flags;
  logic [WIDTH-1:0] acc_d;
  logic [3:0]       flags_d;
  logic             out_valid_d;

  // Single-cycle ALU result; NOP and unlisted ops keep acc and flags
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, operand};
    diff      = {1'b0, acc} - {1'b0, operand};
    res       = acc;
    res_c     = 1'b0;
    res_v     = 1'b0;
    upd_flags = 1'b1;
    case (op)
      OP_LDA: res = operand;
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (acc[WIDTH-1] == operand[WIDTH-1]) && (res[WIDTH-1] != acc[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (acc[WIDTH-1] != operand[WIDTH-1]) && (res[WIDTH-1] != acc[WIDTH-1]);
      end
      OP_AND: res = acc & operand;
      OP_OR:  res = acc | operand;
      OP_XOR: res = acc ^ operand;
      default: upd_flags = 1'b0;
    endcase
  end

`ifdef BIP_ALU_MUL_EN
  localparam logic [2:0]  OP_MUL = 3'b111;
  localparam int unsigned CW     = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state;
  state_e             state_d;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_d;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_d;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] mcand_d;
  logic [2*WIDTH-1:0] prod_sum;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mplier_d;

  assign in_ready = (state == IDLE);

  // Next-state and datapath updates; one multiplier bit is consumed per BUSY edge
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    prod_d      = prod;
    mcand_d     = mcand;
    mplier_d    = mplier;
    acc_d       = acc;
    flags_d     = flags;
    out_valid_d = 1'b0;
    prod_sum    = prod + (mplier[0] ? mcand : '0);
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            state_d  = BUSY;
            cnt_d    = CW'(WIDTH);
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, acc};
            mplier_d = operand;
          end else begin
            acc_d       = res;
            out_valid_d = 1'b1;
            if (upd_flags) flags_d = {(res == '0), res[WIDTH-1], res_c, res_v};
          end
        end
      end
      BUSY: begin
        prod_d   = prod_sum;
        mcand_d  = {mcand[2*WIDTH-2:0], 1'b0};
        mplier_d = mplier >> 1;
        cnt_d    = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_d     = IDLE;
          acc_d       = prod_sum[WIDTH-1:0];
          flags_d     = {(prod_sum[WIDTH-1:0] == '0), prod_sum[WIDTH-1],
                         (prod_sum[2*WIDTH-1:WIDTH] != '0), 1'b0};
          out_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      flags     <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      prod      <= prod_d;
      mcand     <= mcand_d;
      mplier    <= mplier_d;
      acc       <= acc_d;
      flags     <= flags_d;
      out_valid <= out_valid_d;
    end
  end
`else
  assign in_ready = 1'b1;

  // Every valid op completes in one cycle; op 111 falls into the NOP path
  always_comb begin
    acc_d       = acc;
    flags_d     = flags;
    out_valid_d = 1'b0;
    if (in_valid) begin
      acc_d       = res;
      out_valid_d = 1'b1;
      if (upd_flags) flags_d = {(res == '0), res[WIDTH-1], res_c, res_v};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      flags     <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      acc       <= acc_d;
      flags     <= flags_d;
      out_valid <= out_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_bip_alu_acc.sv
// Directed self-checking bench for bip_alu_acc (WIDTH=16); exercises the MUL path
// when BIP_ALU_MUL_EN is defined and the op-111-as-NOP path otherwise.
module tb_bip_alu_acc;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc;
  logic [3:0]       flags;
  logic             out_valid;

  int checks;
  int errors;

  localparam logic [2:0] LDA = 3'b000;
  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] SUB = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] OR  = 3'b100;
  localparam logic [2:0] XOR = 3'b101;
  localparam logic [2:0] NOP = 3'b110;
  localparam logic [2:0] MUL = 3'b111;

  bip_alu_acc #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand   (operand),
    .acc       (acc),
    .flags     (flags),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] acc_e, input logic [3:0] flags_e,
                           input logic ov_e);
    check({tag, ".acc"},       32'(acc),       32'(acc_e));
    check({tag, ".flags"},     32'(flags),     32'(flags_e));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov_e));
  endtask

  // Present one op for one edge; in_valid stays high until the caller idles
  task automatic do_op(input logic [2:0] o, input logic [15:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    operand  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    op       = NOP;
    operand  = '0;
    #1;
    check_res("reset", 16'h0000, 4'b0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // Signed overflow on ADD, back-to-back
    do_op(LDA, 16'h7FFF);
    check_res("lda_7fff", 16'h7FFF, 4'b0000, 1'b1);
    do_op(ADD, 16'h0001);
    check_res("add_ovf", 16'h8000, 4'b0101, 1'b1);
    idle();
    check("idle_no_valid", 32'(out_valid), 32'd0);

    // Carry out of ADD, borrow on SUB
    do_op(LDA, 16'hFFFF);
    check_res("lda_ffff", 16'hFFFF, 4'b0100, 1'b1);
    do_op(ADD, 16'h0001);
    check_res("add_carry", 16'h0000, 4'b1010, 1'b1);
    do_op(LDA, 16'h0003);
    check_res("lda_3", 16'h0003, 4'b0000, 1'b1);
    do_op(SUB, 16'h0005);
    check_res("sub_borrow", 16'hFFFE, 4'b0110, 1'b1);

    // Logic ops clear C/V
    do_op(LDA, 16'h00F0);
    do_op(XOR, 16'h0FF0);
    check_res("xor", 16'h0F00, 4'b0000, 1'b1);
    do_op(NOP, 16'h1234);
    check_res("nop_after_xor", 16'h0F00, 4'b0000, 1'b1);
    do_op(LDA, 16'hF0F0);
    do_op(AND, 16'h0FF0);
    check_res("and", 16'h00F0, 4'b0000, 1'b1);
    do_op(OR, 16'hFF00);
    check_res("or", 16'hFFF0, 4'b0100, 1'b1);

    // SUB signed overflow, then NOP must keep non-zero flags
    do_op(LDA, 16'h8000);
    do_op(SUB, 16'h0001);
    check_res("sub_ovf", 16'h7FFF, 4'b0001, 1'b1);
    do_op(NOP, 16'h5555);
    check_res("nop_keep", 16'h7FFF, 4'b0001, 1'b1);
    idle();
    check("idle2_no_valid", 32'(out_valid), 32'd0);

`ifdef BIP_ALU_MUL_EN
    // 300 * 200 = 60000 with in_valid noise during BUSY
    do_op(LDA, 16'd300);
    do_op(MUL, 16'd200);
    check("mul_accept_ready", 32'(in_ready), 32'd0);
    check("mul_accept_ov", 32'(out_valid), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      in_valid = (k < 16) ? k[0] : 1'b0;
      op       = LDA;
      operand  = 16'(k * 16'h0101);
      @(posedge clk);
      #1;
      if (k < 16) begin
        check($sformatf("mul_busy_ready_%0d", k), 32'(in_ready), 32'd0);
        check($sformatf("mul_busy_ov_%0d", k), 32'(out_valid), 32'd0);
        check($sformatf("mul_busy_acc_%0d", k), 32'(acc), 32'd300);
      end
    end
    check_res("mul_done", 16'hEA60, 4'b0100, 1'b1);
    check("mul_done_ready", 32'(in_ready), 32'd1);
    idle();
    check("mul_single_pulse", 32'(out_valid), 32'd0);

    // Product overflows the low half
    do_op(LDA, 16'h1000);
    do_op(MUL, 16'h0010);
    in_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
    end
    check_res("mul_hi", 16'h0000, 4'b1010, 1'b1);

    // Reset in the middle of a multiply
    do_op(LDA, 16'h0007);
    do_op(MUL, 16'h0003);
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_res("mul_reset", 16'h0000, 4'b0000, 1'b0);
    check("mul_reset_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      check("mul_abort_no_valid", 32'(seen), 32'd0);
    end
    check("mul_abort_ready", 32'(in_ready), 32'd1);
    check("mul_abort_acc", 32'(acc), 32'd0);
`else
    // op 111 without the multiplier acts as NOP
    do_op(LDA, 16'h0005);
    check_res("lda_5", 16'h0005, 4'b0000, 1'b1);
    do_op(MUL, 16'h0003);
    check_res("op111_nop", 16'h0005, 4'b0000, 1'b1);
    check("op111_ready", 32'(in_ready), 32'd1);
    do_op(LDA, 16'h0003);
    do_op(SUB, 16'h0005);
    do_op(MUL, 16'h0003);
    check_res("op111_keep_flags", 16'hFFFE, 4'b0110, 1'b1);
    idle();
    check("op111_idle", 32'(out_valid), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
